// File: rtl/mult_share_arb_if.sv
// Bundle of requester handshakes, shared-multiplier datapath and result bus.
// Ports (grouped as signals):
//   req_valid/req_ready/req_a/req_b : per-requester operand handshakes
//   mult_a/mult_b/mult_p            : registered operands out, product in
//   res_valid/res_id/res_p          : tagged result stream, busy flag
// master: requester/datapath side; slave: arbiter side.
interface mult_share_arb_if #(
   parameter int unsigned WORD_SIZE = 29,
   parameter int unsigned NUM_REQ   = 4
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*WORD_SIZE-1:0] req_a;
   logic [NUM_REQ*WORD_SIZE-1:0] req_b;
   logic [WORD_SIZE-1:0]         mult_a;
   logic [WORD_SIZE-1:0]         mult_b;
   logic [2*WORD_SIZE-1:0]       mult_p;
   logic                         res_valid;
   logic [ID_W-1:0]              res_id;
   logic [2*WORD_SIZE-1:0]       res_p;
   logic                         busy;

   modport master (
      output req_valid, req_a, req_b, mult_p,
      input  req_ready, mult_a, mult_b, res_valid, res_id, res_p, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, mult_p,
      output req_ready, mult_a, mult_b, res_valid, res_id, res_p, busy
   );
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among
// NUM_REQ requesters, with a tag pipeline returning each product to its owner
// and a per-requester cap on in-flight operations.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_share_arb_if.slave (handshakes, datapath, results, busy)
module mult_share_arb #(
   parameter int unsigned WORD_SIZE       = 29,
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned MULT_LATENCY    = 32,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input logic              clk,
   input logic              rst_n,
   mult_share_arb_if.slave  bus
);
   localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic                              r_rdy_en;
   logic [ID_W-1:0]                   r_last;
   logic [WORD_SIZE-1:0]              r_mult_a;
   logic [WORD_SIZE-1:0]              r_mult_b;
   logic [MULT_LATENCY-1:0]           r_vld_pipe;
   logic [MULT_LATENCY-1:0][ID_W-1:0] r_id_pipe;

   logic [NUM_REQ-1:0]   w_elig;
   logic [NUM_REQ-1:0]   w_grant;
   logic [ID_W-1:0]      w_grant_idx;
   logic                 w_hs;
   logic                 w_res_vld;
   logic [ID_W-1:0]      w_res_id;
   logic [WORD_SIZE-1:0] w_a [NUM_REQ];
   logic [WORD_SIZE-1:0] w_b [NUM_REQ];

   assign w_res_vld = r_vld_pipe[MULT_LATENCY-1];
   assign w_res_id  = r_id_pipe[MULT_LATENCY-1];

   // Per-requester operand unpacking, eligibility and outstanding counter
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      logic [CNT_W-1:0] r_cnt;
      logic             w_dec;

      assign w_a[g]    = bus.req_a[g*WORD_SIZE +: WORD_SIZE];
      assign w_b[g]    = bus.req_b[g*WORD_SIZE +: WORD_SIZE];
      assign w_dec     = w_res_vld && (w_res_id == ID_W'(g));
      assign w_elig[g] = r_rdy_en && bus.req_valid[g] &&
                         (r_cnt < CNT_W'(MAX_OUTSTANDING));

      // Issue and retire on the same edge cancel out
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_grant[g] && !w_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (w_dec && !w_grant[g]) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end

      // Counter range checks
      always @(posedge clk) begin
         if (rst_n) begin
            if (w_grant[g] && !w_dec)
               assert (r_cnt < CNT_W'(MAX_OUTSTANDING));
            if (w_dec && !w_grant[g])
               assert (r_cnt != '0);
         end
      end
   end

   // Round-robin search starting one past the last granted requester
   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_hs        = 1'b0;
      w_grant_idx = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = 32'(r_last) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_hs && w_elig[ID_W'(idx)]) begin
            w_hs        = 1'b1;
            w_grant_idx = ID_W'(idx);
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_hs) w_grant[w_grant_idx] = 1'b1;
   end

   // Grant pointer, operand registers and the post-reset ready guard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
         r_last   <= ID_W'(NUM_REQ - 1);
         r_mult_a <= '0;
         r_mult_b <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_hs) begin
            r_last   <= w_grant_idx;
            r_mult_a <= w_a[w_grant_idx];
            r_mult_b <= w_b[w_grant_idx];
         end
      end
   end

   // Tag pipeline mirrors the multiplier latency; never stalls
   if (MULT_LATENCY > 1) begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
         end else begin
            r_vld_pipe <= {r_vld_pipe[MULT_LATENCY-2:0], w_hs};
            r_id_pipe  <= {r_id_pipe[MULT_LATENCY-2:0], w_grant_idx};
         end
      end
   end else begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
         end else begin
            r_vld_pipe <= w_hs;
            r_id_pipe  <= w_grant_idx;
         end
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.mult_a    = r_mult_a;
   assign bus.mult_b    = r_mult_b;
   assign bus.res_valid = w_res_vld;
   assign bus.res_id    = w_res_id;
   assign bus.res_p     = bus.mult_p;
   assign bus.busy      = |r_vld_pipe;
endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed phases plus random traffic, checked
// against a sliding-window reference of issues and expected products.
module tb_mult_share_arb;
   localparam int W    = 29;
   localparam int N    = 4;
   localparam int L    = 32;
   localparam int MAXO = 8;
   localparam int P_W  = 2*W;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_share_arb_if #(.WORD_SIZE(W), .NUM_REQ(N)) bus ();

   mult_share_arb #(
      .WORD_SIZE(W), .NUM_REQ(N), .MULT_LATENCY(L), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // Shared multiplier: registered operands plus L-1 stages line up with the tag
   logic [P_W-1:0] mpipe [0:L-2];
   always @(posedge clk) begin
      mpipe[0] <= P_W'(bus.mult_a) * P_W'(bus.mult_b);
      for (int s = 1; s < L-1; s++) mpipe[s] <= mpipe[s-1];
   end
   assign bus.mult_p = mpipe[L-2];

   // Reference: issue log indexed by edge number since reset release
   int             t;
   int             m_last;
   int             exp_gnt;
   bit             iss_v  [MAXC];
   int             iss_id [MAXC];
   logic [P_W-1:0] iss_p  [MAXC];
   logic [W-1:0]   a_in [N];
   logic [W-1:0]   b_in [N];
   logic [N-1:0]   v_in;
   int             n_pass, n_fail, n_chk;
   int             te;
   logic [63:0]    big;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req_valid = v_in;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*W +: W] = a_in[i];
         bus.req_b[i*W +: W] = b_in[i];
      end
   endtask

   task automatic model_reset();
      t = 0;
      m_last = N-1;
      for (int k = 0; k < MAXC; k++) iss_v[k] = 1'b0;
   endtask

   // Operations of requester i still counted against its cap after edge t
   function automatic int outst(input int i);
      int c;
      c = 0;
      for (int k = t-L+1; k <= t; k++)
         if (k >= 1 && iss_v[k] && iss_id[k] == i) c++;
      return c;
   endfunction

   task automatic check_cycle();
      logic [N-1:0] er;
      int k, idx;
      bit eb;
      exp_gnt = -1;
      if (t >= 1) begin
         for (int off = 1; off <= N; off++) begin
            idx = (m_last + off) % N;
            if (exp_gnt < 0 && v_in[idx] && outst(idx) < MAXO) exp_gnt = idx;
         end
      end
      er = '0;
      if (exp_gnt >= 0) er[exp_gnt] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      k = t - L + 1;
      if (k >= 1 && iss_v[k]) begin
         chk("res_valid", 64'(bus.res_valid), 64'd1);
         chk("res_id", 64'(bus.res_id), 64'(iss_id[k]));
         chk("res_p", 64'(bus.res_p), 64'(iss_p[k]));
      end else begin
         chk("res_valid_idle", 64'(bus.res_valid), 64'd0);
      end
      eb = 1'b0;
      for (int j = t-L+1; j <= t; j++) if (j >= 1 && iss_v[j]) eb = 1'b1;
      chk("busy", 64'(bus.busy), 64'(eb));
   endtask

   task automatic model_edge();
      t++;
      iss_v[t] = 1'b0;
      if (exp_gnt >= 0) begin
         iss_v[t]  = 1'b1;
         iss_id[t] = exp_gnt;
         iss_p[t]  = P_W'(a_in[exp_gnt]) * P_W'(b_in[exp_gnt]);
         m_last    = exp_gnt;
      end
   endtask

   // One clock: check at negedge+1, advance model at posedge, return at negedge
   task automatic cyc();
      drive();
      #1 check_cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         a_in[i] = W'($urandom);
         b_in[i] = W'($urandom);
      end
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_chk = 0;
      v_in = '0;
      for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
      drive();
      model_reset();

      // Reset state
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready", 64'(bus.req_ready), 64'd0);
         chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
         chk("rst_res_id", 64'(bus.res_id), 64'd0);
         chk("rst_busy", 64'(bus.busy), 64'd0);
      end
      rst_n = 1'b1;
      model_reset();

      // Single op from requester 0 (held through the guard cycle)
      v_in = 4'b0001; a_in[0] = 29'd3; b_in[0] = 29'd5;
      cyc();
      cyc();
      te = t;
      v_in = '0;
      while (t < te + L - 1) cyc();
      chk("single_rv", 64'(bus.res_valid), 64'd1);
      chk("single_id", 64'(bus.res_id), 64'd0);
      chk("single_p", 64'(bus.res_p), 64'd15);
      repeat (3) cyc();

      // Round-robin with all requesters valid
      v_in = 4'b1111;
      repeat (48) begin rand_ops(); cyc(); end
      v_in = '0;
      repeat (L+2) cyc();

      // Outstanding cap with requester 2 alone
      v_in = 4'b0100;
      repeat (48) begin rand_ops(); cyc(); end
      v_in = '0;
      repeat (L+2) cyc();

      // Issue on the same edge as the requester's own retire
      v_in = 4'b0010; rand_ops();
      cyc();
      v_in = '0;
      repeat (L-1) cyc();
      chk("simul_rv", 64'(bus.res_valid), 64'd1);
      chk("simul_id", 64'(bus.res_id), 64'd1);
      v_in = 4'b0010; rand_ops();
      cyc();
      v_in = '0;
      repeat (L+2) cyc();

      // Random traffic
      repeat (300) begin
         v_in = N'($urandom);
         rand_ops();
         cyc();
      end
      v_in = '0;
      repeat (L+2) cyc();

      // Asynchronous reset while three ops are in flight
      v_in = 4'b0111;
      repeat (3) begin rand_ops(); cyc(); end
      v_in = '0;
      drive();
      #1 check_cycle();
      @(posedge clk);
      model_edge();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'(bus.req_ready), 64'd0);
      chk("midrst_rv", 64'(bus.res_valid), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_id", 64'(bus.res_id), 64'd0);
      #1 rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      repeat (L+2) cyc();
      v_in = 4'b1111; rand_ops();
      drive();
      #1 chk("post_rst_grant", 64'(bus.req_ready), 64'd1);
      cyc();
      v_in = '0;
      repeat (L+2) cyc();

      // Extreme operands on requester 3
      v_in = 4'b1000;
      a_in[3] = '1; b_in[3] = '1;
      big = (64'd1 << (2*W)) - (64'd1 << (W+1)) + 64'd1;
      cyc();
      te = t;
      v_in = '0;
      while (t < te + L - 1) cyc();
      chk("max_rv", 64'(bus.res_valid), 64'd1);
      chk("max_id", 64'(bus.res_id), 64'd3);
      chk("max_p", 64'(bus.res_p), big);
      repeat (3) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
